// File: rtl/neuron_pkg.sv
// +------------------------------------------------------------------------+
// | Package     : neuron_pkg                                               |
// | Description : Shared defaults and loader state type for the neuron     |
// |               operand loader and its register file.                    |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
`default_nettype none

package neuron_pkg;

  localparam int N_DEF  = 10;  // operand pairs per frame
  localparam int DW_DEF = 8;   // operand width
  localparam int IDX_W  = 16;  // width of the neuron operand index

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FIRE = 2'd1,
    ARM  = 2'd2,
    WAIT = 2'd3
  } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/operand_regfile.sv
// +------------------------------------------------------------------------+
// | Module      : operand_regfile                                          |
// | Description : N-entry (input, weight) operand store. One write port,   |
// |               combinational read by index; out-of-range reads give 0.  |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
`default_nettype none

module operand_regfile
  import neuron_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF
) (
  input  logic             clk,
  input  logic             rst,       // synchronous, active-low
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [DW-1:0]    wdata_in,
  input  logic [DW-1:0]    wdata_w,
  input  logic [IDX_W-1:0] raddr,
  output logic [DW-1:0]    rdata_in,
  output logic [DW-1:0]    rdata_w
);

  logic [N-1:0][DW-1:0] in_q, in_d;
  logic [N-1:0][DW-1:0] w_q,  w_d;

  // Next-state of the storage: only the addressed entry changes on a write.
  always_comb begin
    in_d = in_q;
    w_d  = w_q;
    for (int i = 0; i < N; i++) begin
      if (we && (waddr == IDX_W'(i))) begin
        in_d[i] = wdata_in;
        w_d[i]  = wdata_w;
      end
    end
  end

  // Storage flops; reset clears every entry so a discarded frame leaves zeros.
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_q <= '0;
      w_q  <= '0;
    end else begin
      in_q <= in_d;
      w_q  <= w_d;
    end
  end

  // Index-addressed read; an index that matches no entry falls through to 0.
  always_comb begin
    rdata_in = '0;
    rdata_w  = '0;
    for (int i = 0; i < N; i++) begin
      if (raddr == IDX_W'(i)) begin
        rdata_in = in_q[i];
        rdata_w  = w_q[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/neuron_operand_loader.sv
// +------------------------------------------------------------------------+
// | Module      : neuron_operand_loader                                    |
// | Description : Loads one frame of (input, weight) pairs, fires the      |
// |               neuron, serves its operand reads and captures the result.|
// | Options     : LOADER_LAST_CHECK_EN - enable s_last framing check / err |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
`default_nettype none

module neuron_operand_loader
  import neuron_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF
) (
  input  logic             clk,
  input  logic             rst,        // synchronous, active-low
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DW-1:0]    s_in,
  input  logic [DW-1:0]    s_w,
  input  logic             s_last,
  output logic             nrn_start,
  input  logic [IDX_W-1:0] nrn_idx,
  output logic [DW-1:0]    nrn_in,
  output logic [DW-1:0]    nrn_w,
  input  logic             nrn_ready,
  input  logic [15:0]      nrn_out,
  output logic [15:0]      res_data,
  output logic             res_valid,
  output logic             err
);

  loader_state_t    state_q, state_d;
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [15:0]      res_data_q, res_data_d;
  logic             res_valid_q, res_valid_d;
  logic             err_q, err_d;

  logic hs;         // pair handshake this cycle
  logic last_ptr;   // write pointer sits on the final entry of the frame
  logic frame_err;  // accepted pair violates s_last framing
  logic we;

  // Handshake and start are pure state decodes, forced low while in reset.
  assign s_ready   = rst && (state_q == LOAD);
  assign nrn_start = rst && (state_q == FIRE);
  assign hs        = s_valid && s_ready;
  assign last_ptr  = (wr_ptr_q == IDX_W'(N - 1));

`ifdef LOADER_LAST_CHECK_EN
  assign frame_err = hs && (s_last != last_ptr);
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
  assign frame_err     = 1'b0;
`endif

  // A pair that breaks framing is dropped rather than written.
  assign we = hs && !frame_err;

  // Loader control: frame fill, start pulse, stale-ready guard, result capture.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    res_data_d  = res_data_q;
    res_valid_d = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      LOAD: begin
        if (hs) begin
          if (frame_err) begin
            err_d    = 1'b1;
            wr_ptr_d = '0;
          end else if (last_ptr) begin
            wr_ptr_d = '0;
            state_d  = FIRE;
          end else begin
            wr_ptr_d = wr_ptr_q + IDX_W'(1);
          end
        end
      end
      FIRE: state_d = ARM;
      // nrn_ready may still be high from the previous run; skip one cycle.
      ARM:  state_d = WAIT;
      WAIT: begin
        if (nrn_ready) begin
          res_data_d  = nrn_out;
          res_valid_d = 1'b1;
          state_d     = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= LOAD;
      wr_ptr_q    <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
    end
  end

  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign err       = err_q;

  operand_regfile #(
    .N  (N),
    .DW (DW)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (wr_ptr_q),
    .wdata_in (s_in),
    .wdata_w  (s_w),
    .raddr    (nrn_idx),
    .rdata_in (nrn_in),
    .rdata_w  (nrn_w)
  );

endmodule

`default_nettype wire

// File: tb/tb_neuron_operand_loader.sv
// +------------------------------------------------------------------------+
// | Module      : tb_neuron_operand_loader                                 |
// | Description : Self-checking bench for neuron_operand_loader with a     |
// |               frame-level reference model and per-cycle comparison.    |
// | Options     : LOADER_LAST_CHECK_EN - model follows the framing check   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_neuron_operand_loader;

  localparam int N = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        nrn_ready = 1'b0;
  logic [7:0]  s_in = 8'd0;
  logic [7:0]  s_w = 8'd0;
  logic [15:0] nrn_idx = 16'd0;
  logic [15:0] nrn_out = 16'd0;
  logic        s_ready, nrn_start, res_valid, err;
  logic [7:0]  nrn_in, nrn_w;
  logic [15:0] res_data;

  always #5 clk = ~clk;

  neuron_operand_loader #(.N(N), .DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_in      (s_in),
    .s_w       (s_w),
    .s_last    (s_last),
    .nrn_start (nrn_start),
    .nrn_idx   (nrn_idx),
    .nrn_in    (nrn_in),
    .nrn_w     (nrn_w),
    .nrn_ready (nrn_ready),
    .nrn_out   (nrn_out),
    .res_data  (res_data),
    .res_valid (res_valid),
    .err       (err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int start_cnt = 0;
  int rv_cnt = 0;
  int err_cnt = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  // A frame of N accepted pairs makes the loader busy. While busy no pair is
  // taken; the result is the first nrn_ready seen at least three edges after
  // the completing handshake (start cycle and one guard cycle are skipped).
  logic [7:0]  m_in [0:65535];
  logic [7:0]  m_w  [0:65535];
  int          m_cnt = 0;
  int          m_age = 0;
  bit          m_busy = 1'b0, m_start = 1'b0, m_rv = 1'b0, m_err = 1'b0;
  logic [15:0] m_res = 16'd0;

  always @(posedge clk) begin
    bit bad;
    m_start = 1'b0;
    m_rv    = 1'b0;
    m_err   = 1'b0;
    if (!rst) begin
      for (int i = 0; i < 65536; i++) begin
        m_in[i] = 8'd0;
        m_w[i]  = 8'd0;
      end
      m_cnt  = 0;
      m_busy = 1'b0;
      m_res  = 16'd0;
    end else if (!m_busy) begin
      if (s_valid) begin
        bad = 1'b0;
`ifdef LOADER_LAST_CHECK_EN
        bad = (s_last != (m_cnt == N - 1));
`endif
        if (bad) begin
          m_err = 1'b1;
          m_cnt = 0;
        end else begin
          m_in[16'(m_cnt)] = s_in;
          m_w[16'(m_cnt)]  = s_w;
          m_cnt++;
          if (m_cnt == N) begin
            m_cnt   = 0;
            m_busy  = 1'b1;
            m_age   = 0;
            m_start = 1'b1;
          end
        end
      end
    end else begin
      m_age++;
      if (m_age >= 3 && nrn_ready) begin
        m_res  = nrn_out;
        m_rv   = 1'b1;
        m_busy = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("s_ready",   s_ready,   rst && !m_busy);
      chk("nrn_start", nrn_start, rst && m_start);
      chk("res_valid", res_valid, m_rv);
      chk("res_data",  res_data,  m_res);
      chk("err",       err,       m_err);
      chk("nrn_in",    nrn_in,    m_in[nrn_idx]);
      chk("nrn_w",     nrn_w,     m_w[nrn_idx]);
      if (nrn_start) start_cnt++;
      if (res_valid) rv_cnt++;
      if (err)       err_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [7:0] i;
    logic [7:0] w;
    logic       l;
  } pair_t;
  pair_t txq[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rnd_idx();
    return ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 15));
  endfunction

  // Streams txq with s_valid held whenever data remains; a neuron stub
  // answers each start after a random delay and also toggles ready at random.
  task automatic run_stream(input int budget);
    int cd;
    bit hs;
    bit done;
    cd   = 0;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      s_valid = (txq.size() > 0);
      if (txq.size() > 0) begin
        s_in = txq[0].i; s_w = txq[0].w; s_last = txq[0].l;
      end
      @(negedge clk);
      hs = s_valid && s_ready;
      if (nrn_start) cd = $urandom_range(2, 8);
      step();
      if (hs) void'(txq.pop_front());
      nrn_idx = rnd_idx();
      nrn_out = 16'($urandom);
      if (cd > 0) begin
        cd--;
        nrn_ready = (cd == 0);
      end else begin
        nrn_ready = ($urandom_range(0, 3) == 0);
      end
      if (txq.size() == 0 && !m_busy) done = 1'b1;
    end
    s_valid   = 1'b0;
    nrn_ready = 1'b0;
    chk("stream_done", {31'd0, done}, 32'd1);
  endtask

  logic [7:0] f2_in [N];
  logic [7:0] f2_w  [N];
  int         base;

  initial begin
    // Reset
    rst = 1'b0;
    step(); chk_en = 1'b1; step(); step();
    @(negedge clk);
    chk("reset_s_ready", s_ready, 0);
    chk("reset_res_data", res_data, 0);
    chk("reset_nrn_in", nrn_in, 0);

    // Load and fire with stale nrn_ready held high
    step();
    rst = 1'b1; nrn_ready = 1'b1; nrn_out = 16'hDEAD;
    for (int k = 0; k < N; k++) begin
      s_valid = 1'b1; s_in = 8'(k + 1); s_w = 8'd2; s_last = (k == N - 1);
      nrn_idx = rnd_idx();
      step();
    end
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    chk("fire_start", nrn_start, 1);
    chk("fire_s_ready", s_ready, 0);
    step();               // ARM
    step();               // WAIT
    nrn_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      nrn_idx = (k < N) ? 16'(k) : ((k == N) ? 16'd10 : 16'hFFFF);
      @(negedge clk);
      chk("sweep_in", nrn_in, (k < N) ? 32'(k + 1) : 32'd0);
      chk("sweep_w",  nrn_w,  (k < N) ? 32'd2 : 32'd0);
      step();
    end
    nrn_ready = 1'b1; nrn_out = 16'h006E;
    step();
    nrn_ready = 1'b0;
    @(negedge clk);
    chk("cap_res_valid", res_valid, 1);
    chk("cap_res_data", res_data, 16'h006E);
    chk("cap_s_ready", s_ready, 1);
    step(); step(); step();
    chk("one_start", start_cnt, 1);
    chk("one_res_valid", rv_cnt, 1);

    // Backpressure: two frames streamed with s_valid held high
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < N; k++) begin
        pair_t p;
        p.i = 8'($urandom); p.w = 8'($urandom); p.l = (k == N - 1);
        if (f == 1) begin f2_in[k] = p.i; f2_w[k] = p.w; end
        txq.push_back(p);
      end
    end
    run_stream(600);
    step(); step();
    chk("bp_starts", start_cnt, 3);
    chk("bp_results", rv_cnt, 3);
    for (int k = 0; k < N; k++) begin
      nrn_idx = 16'(k);
      @(negedge clk);
      chk("bp_sweep_in", nrn_in, f2_in[k]);
      chk("bp_sweep_w",  nrn_w,  f2_w[k]);
      step();
    end

    // Reset mid-operation during WAIT
    nrn_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      s_valid = 1'b1; s_in = 8'($urandom_range(1, 255)); s_w = 8'($urandom_range(1, 255));
      s_last = (k == N - 1);
      step();
    end
    s_valid = 1'b0; s_last = 1'b0;
    step(); step(); step();   // FIRE -> ARM -> WAIT, one WAIT cycle
    rst = 1'b0; nrn_idx = 16'd0;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_s_ready", s_ready, 1);
    chk("rstmid_entry0", nrn_in, 0);
    base = rv_cnt;
    nrn_ready = 1'b1; nrn_out = 16'h1234;
    for (int k = 0; k < 5; k++) begin
      nrn_idx = rnd_idx();
      step();
    end
    nrn_ready = 1'b0;
    step();
    chk("rstmid_no_result", rv_cnt - base, 0);
    chk("rstmid_res_data", res_data, 0);

    // Framing: s_last on pair 4, then a well-framed frame
    base = start_cnt;
    for (int k = 0; k < 5; k++) begin
      pair_t p;
      p.i = 8'($urandom); p.w = 8'($urandom); p.l = (k == 4);
      txq.push_back(p);
    end
    for (int k = 0; k < N; k++) begin
      pair_t p;
      p.i = 8'($urandom); p.w = 8'($urandom); p.l = (k == N - 1);
      txq.push_back(p);
    end
    run_stream(400);
    step(); step();
    chk("frame_starts", start_cnt - base, 1);
`ifdef LOADER_LAST_CHECK_EN
    chk("frame_err_count", err_cnt, 1);
`else
    chk("frame_err_count", err_cnt, 0);
`endif

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
